// File: rtl/me_pkg.sv
// Shared types and width helpers for the full-search motion estimator.
package me_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoadCur,
        StSearch,
        StFlush
    } me_state_e;

    // Width holding a full block SAD without overflow.
    function automatic int unsigned sad_width(input int unsigned macro_dim,
                                              input int unsigned pix_w);
        return $clog2(macro_dim * macro_dim * ((2 ** pix_w) - 1) + 1);
    endfunction

    // Width holding one column's SAD without overflow.
    function automatic int unsigned col_width(input int unsigned macro_dim,
                                              input int unsigned pix_w);
        return $clog2(macro_dim * ((2 ** pix_w) - 1) + 1);
    endfunction

    // Signed motion-vector width for n candidate positions per axis.
    function automatic int unsigned mv_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/me_col_sad.sv
// Sum of absolute differences between one current-block column and one search column.
module me_col_sad
    import me_pkg::*;
#(
    parameter int unsigned MACRO_DIM = 16,
    parameter int unsigned PIX_W     = 8,
    localparam int unsigned COL_W    = col_width(MACRO_DIM, PIX_W)
) (
    input  logic [MACRO_DIM*PIX_W-1:0] cur_col_i,
    input  logic [MACRO_DIM*PIX_W-1:0] spr_col_i,
    output logic [COL_W-1:0]           sad_o
);

    logic [MACRO_DIM-1:0][PIX_W-1:0] abs_diff;

    for (genvar r = 0; r < MACRO_DIM; r++) begin : g_abs
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
        assign a           = cur_col_i[r*PIX_W +: PIX_W];
        assign b           = spr_col_i[r*PIX_W +: PIX_W];
        assign abs_diff[r] = (a > b) ? (a - b) : (b - a);
    end

    // Adder tree over the per-row absolute differences.
    always_comb begin
        sad_o = '0;
        for (int r = 0; r < MACRO_DIM; r++) begin
            sad_o = sad_o + COL_W'(abs_diff[r]);
        end
    end

endmodule

// File: rtl/me_full_search.sv
// Full-search block matcher: loads a current block, streams every candidate column by
// column, and reports the minimum SAD and its displacement from the window centre.
module me_full_search
    import me_pkg::*;
#(
    parameter int unsigned MACRO_DIM  = 16,
    parameter int unsigned SEARCH_DIM = 48,
    parameter int unsigned PIX_W      = 8,
    localparam int unsigned N         = SEARCH_DIM - MACRO_DIM + 1,
    localparam int unsigned OFS       = (SEARCH_DIM - MACRO_DIM) / 2,
    localparam int unsigned SAD_W     = sad_width(MACRO_DIM, PIX_W),
    localparam int unsigned MV_W      = mv_width(N)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          cpr_valid,
    input  logic [MACRO_DIM*PIX_W-1:0]    pixel_cpr_in,
    input  logic                          spr_valid,
    output logic                          spr_ready,
    input  logic [MACRO_DIM*PIX_W-1:0]    pixel_spr_in,
    output logic                          busy,
    output logic                          valid,
    output logic [SAD_W-1:0]              min_sad,
    output logic signed [MV_W-1:0]        mv_x,
    output logic signed [MV_W-1:0]        mv_y
);

    localparam int unsigned CNT_W  = $clog2(N);
    localparam int unsigned BEAT_W = $clog2(MACRO_DIM);
    localparam int unsigned DIST_W = CNT_W + 1;
    localparam int unsigned COL_W  = col_width(MACRO_DIM, PIX_W);

    localparam logic [BEAT_W-1:0] BeatLast = BEAT_W'(MACRO_DIM - 1);
    localparam logic [CNT_W-1:0]  PosLast  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  PosOfs   = CNT_W'(OFS);

    me_state_e state_q, state_d;

    logic [MACRO_DIM-1:0][MACRO_DIM*PIX_W-1:0] cur_q;
    logic [BEAT_W-1:0] ld_cnt_q;
    logic [BEAT_W-1:0] beat_q;
    logic [CNT_W-1:0]  dx_q, dy_q;

    logic accept, beat_last, final_beat, load_done;

    // Stage 1 registers
    logic              s1_vld_q, s1_first_q, s1_last_q, s1_final_q;
    logic [COL_W-1:0]  s1_sad_q;
    logic [CNT_W-1:0]  s1_dx_q, s1_dy_q;
    logic [COL_W-1:0]  col_sad;

    // Stage 2 state
    logic [SAD_W-1:0]  acc_q, acc_sum;
    logic [SAD_W-1:0]  best_sad_q;
    logic [CNT_W-1:0]  best_dx_q, best_dy_q;
    logic [DIST_W-1:0] best_dist_q, cand_dist;
    logic [CNT_W-1:0]  dx_off, dy_off;
    logic              better, s2_done_q;

    logic              valid_q;
    logic [SAD_W-1:0]  min_sad_q;
    logic [MV_W-1:0]   mv_x_q, mv_y_q;

    assign spr_ready  = (state_q == StSearch);
    assign busy       = (state_q != StIdle);
    assign accept     = spr_valid && spr_ready;
    assign beat_last  = (beat_q == BeatLast);
    assign final_beat = accept && beat_last && (dx_q == PosLast) && (dy_q == PosLast);
    assign load_done  = (state_q == StLoadCur) && cpr_valid && (ld_cnt_q == BeatLast);

    me_col_sad #(
        .MACRO_DIM (MACRO_DIM),
        .PIX_W     (PIX_W)
    ) u_col_sad (
        .cur_col_i (cur_q[beat_q]),
        .spr_col_i (pixel_spr_in),
        .sad_o     (col_sad)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; start outside IDLE is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start)      state_d = StLoadCur;
            StLoadCur: if (load_done)  state_d = StSearch;
            StSearch:  if (final_beat) state_d = StFlush;
            StFlush:   if (s2_done_q)  state_d = StIdle;
            default:                   state_d = StIdle;
        endcase
    end

    // Current-block capture and candidate scan counters; stalls when spr_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q    <= '0;
            ld_cnt_q <= '0;
            beat_q   <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else if (state_q == StIdle) begin
            ld_cnt_q <= '0;
            beat_q   <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            if (state_q == StLoadCur && cpr_valid) begin
                cur_q[ld_cnt_q] <= pixel_cpr_in;
                ld_cnt_q        <= (ld_cnt_q == BeatLast) ? '0 : ld_cnt_q + BEAT_W'(1);
            end
            if (accept) begin
                if (beat_last) begin
                    beat_q <= '0;
                    if (dx_q == PosLast) begin
                        dx_q <= '0;
                        dy_q <= (dy_q == PosLast) ? '0 : dy_q + CNT_W'(1);
                    end else begin
                        dx_q <= dx_q + CNT_W'(1);
                    end
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
        end
    end

    // Stage 1: register the column SAD with its candidate position tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_final_q <= 1'b0;
            s1_sad_q   <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_sad_q   <= col_sad;
                s1_first_q <= (beat_q == '0);
                s1_last_q  <= beat_last;
                s1_final_q <= final_beat;
                s1_dx_q    <= dx_q;
                s1_dy_q    <= dy_q;
            end
        end
    end

    // Stage 2 combinational: running candidate SAD, centre distance and best comparison.
    always_comb begin
        acc_sum   = (s1_first_q ? '0 : acc_q) + SAD_W'(s1_sad_q);
        dx_off    = (s1_dx_q >= PosOfs) ? (s1_dx_q - PosOfs) : (PosOfs - s1_dx_q);
        dy_off    = (s1_dy_q >= PosOfs) ? (s1_dy_q - PosOfs) : (PosOfs - s1_dy_q);
        cand_dist = {1'b0, dx_off} + {1'b0, dy_off};
        better    = (acc_sum < best_sad_q) ||
                    ((acc_sum == best_sad_q) && (cand_dist < best_dist_q));
    end

    // Stage 2: accumulate and keep the best candidate; re-initialised when SEARCH begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            best_sad_q  <= '0;
            best_dx_q   <= '0;
            best_dy_q   <= '0;
            best_dist_q <= '0;
            s2_done_q   <= 1'b0;
        end else begin
            s2_done_q <= s1_vld_q && s1_final_q;
            if (s1_vld_q) begin
                acc_q <= acc_sum;
                if (s1_last_q && better) begin
                    best_sad_q  <= acc_sum;
                    best_dx_q   <= s1_dx_q;
                    best_dy_q   <= s1_dy_q;
                    best_dist_q <= cand_dist;
                end
            end
            if (load_done) begin
                best_sad_q  <= '1;
                best_dx_q   <= PosOfs;
                best_dy_q   <= PosOfs;
                best_dist_q <= '0;
            end
        end
    end

    // Result registers: strobe once the last candidate has been folded in, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            min_sad_q <= '0;
            mv_x_q    <= '0;
            mv_y_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == StFlush && s2_done_q) begin
                valid_q   <= 1'b1;
                min_sad_q <= best_sad_q;
                mv_x_q    <= {1'b0, best_dx_q} - MV_W'(OFS);
                mv_y_q    <= {1'b0, best_dy_q} - MV_W'(OFS);
            end
        end
    end

    assign valid   = valid_q;
    assign min_sad = min_sad_q;
    assign mv_x    = $signed(mv_x_q);
    assign mv_y    = $signed(mv_y_q);

endmodule

// File: tb/tb_me_full_search.sv
// Scoreboard bench for me_full_search at MACRO_DIM=4, SEARCH_DIM=8, PIX_W=8.
module tb_me_full_search;

    localparam int MD  = 4;
    localparam int SD  = 8;
    localparam int PW  = 8;
    localparam int NN  = SD - MD + 1;
    localparam int OF  = (SD - MD) / 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cpr_valid = 1'b0;
    logic [MD*PW-1:0]  pixel_cpr_in = '0;
    logic              spr_valid = 1'b0;
    logic              spr_ready;
    logic [MD*PW-1:0]  pixel_spr_in = '0;
    logic              busy;
    logic              valid;
    logic [11:0]       min_sad;
    logic signed [3:0] mv_x;
    logic signed [3:0] mv_y;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_acc = 0;

    int cur_m [MD][MD];
    int win   [SD][SD];

    typedef struct {
        int sad;
        int mx;
        int my;
    } exp_t;
    exp_t exp_q[$];

    me_full_search #(
        .MACRO_DIM    (MD),
        .SEARCH_DIM   (SD),
        .PIX_W        (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cpr_valid    (cpr_valid),
        .pixel_cpr_in (pixel_cpr_in),
        .spr_valid    (spr_valid),
        .spr_ready    (spr_ready),
        .pixel_spr_in (pixel_spr_in),
        .busy         (busy),
        .valid        (valid),
        .min_sad      (min_sad),
        .mv_x         (mv_x),
        .mv_y         (mv_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge counter and index of the most recent accepted search beat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spr_valid && spr_ready) last_acc <= cyc;
    end

    // Scoreboard: every valid strobe pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("min_sad", int'(min_sad), e.sad);
                check("mv_x", int'(mv_x), e.mx);
                check("mv_y", int'(mv_y), e.my);
                check("latency", cyc - last_acc - 1, 2);
            end
        end
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference exhaustive search with centre-distance tie-break.
    task automatic model(output int sad, output int mx, output int my);
        int best, bdx, bdy, s;
        best = 4095;
        bdx  = OF;
        bdy  = OF;
        for (int dy = 0; dy < NN; dy++) begin
            for (int dx = 0; dx < NN; dx++) begin
                s = 0;
                for (int r = 0; r < MD; r++)
                    for (int c = 0; c < MD; c++)
                        s += iabs(cur_m[r][c] - win[dy + r][dx + c]);
                if (s < best || (s == best &&
                    iabs(dx - OF) + iabs(dy - OF) < iabs(bdx - OF) + iabs(bdy - OF))) begin
                    best = s;
                    bdx  = dx;
                    bdy  = dy;
                end
            end
        end
        sad = best;
        mx  = bdx - OF;
        my  = bdy - OF;
    endtask

    task automatic fill_random();
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) cur_m[r][c] = int'($urandom_range(0, 255));
        for (int r = 0; r < SD; r++)
            for (int c = 0; c < SD; c++) win[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic copy_at(input int dx, input int dy);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) win[dy + r][dx + c] = cur_m[r][c];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(spr_ready), 0);
        check({tag, "_sad"}, int'(min_sad), 0);
        check({tag, "_mvx"}, int'(mv_x), 0);
        check({tag, "_mvy"}, int'(mv_y), 0);
    endtask

    // One full search; abort_at >= 0 pulses rst after that many accepted beats.
    task automatic run_search(input bit gap, input int abort_at, input bit start_mid);
        exp_t e;
        int   b;
        int   t;
        if (abort_at < 0) begin
            model(e.sad, e.mx, e.my);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_load", int'(busy), 1);
        for (int c = 0; c < MD; c++) begin
            cpr_valid = 1'b1;
            for (int r = 0; r < MD; r++) pixel_cpr_in[r*PW +: PW] = PW'(cur_m[r][c]);
            @(negedge clk);
        end
        cpr_valid = 1'b0;
        b = 0;
        for (int dy = 0; dy < NN; dy++) begin
            for (int dx = 0; dx < NN; dx++) begin
                for (int c = 0; c < MD; c++) begin
                    if (b == abort_at) begin
                        spr_valid = 1'b0;
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check_idle_outputs("abort");
                        repeat (10) @(negedge clk);
                        return;
                    end
                    start = start_mid && (b == 37);
                    if (gap) begin
                        spr_valid = 1'b0;
                        @(negedge clk);
                    end
                    spr_valid = 1'b1;
                    for (int r = 0; r < MD; r++)
                        pixel_spr_in[r*PW +: PW] = PW'(win[dy + r][dx + c]);
                    t = 0;
                    while (!spr_ready && t < 10) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 10) begin
                        check("spr_ready_timeout", 0, 1);
                        spr_valid = 1'b0;
                        start = 1'b0;
                        return;
                    end
                    @(negedge clk);
                    b++;
                end
            end
        end
        spr_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_result();
        int t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", 0, 1);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_spec(input string tag, input int sad, input int mx, input int my);
        check({tag, "_sad"}, int'(min_sad), sad);
        check({tag, "_mvx"}, int'(mv_x), mx);
        check({tag, "_mvy"}, int'(mv_y), my);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        // Exact copy at (3,1).
        fill_random();
        copy_at(3, 1);
        run_search(1'b0, -1, 1'b0);
        wait_result();
        check_spec("copy", 0, 1, -1);

        // Uniform mismatch: centre wins the tie.
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) cur_m[r][c] = 0;
        for (int r = 0; r < SD; r++)
            for (int c = 0; c < SD; c++) win[r][c] = 255;
        run_search(1'b0, -1, 1'b0);
        wait_result();
        check_spec("tie", 4080, 0, 0);

        // Two exact copies equidistant from centre: first in scan order wins.
        fill_random();
        copy_at(0, 2);
        copy_at(4, 2);
        run_search(1'b0, -1, 1'b0);
        wait_result();
        check_spec("scan", 0, -2, 0);

        // Throttled search beats.
        fill_random();
        copy_at(3, 1);
        run_search(1'b1, -1, 1'b0);
        wait_result();
        check_spec("gap", 0, 1, -1);

        // Abort after 50 beats, then a clean rerun.
        run_search(1'b0, 50, 1'b0);
        run_search(1'b0, -1, 1'b0);
        wait_result();
        check_spec("rerun", 0, 1, -1);

        // Stray start during SEARCH.
        run_search(1'b0, -1, 1'b1);
        wait_result();
        check_spec("start_mid", 0, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
